// File: rtl/syscall_unit.sv
// Sequential console-service engine: decodes $v0/$a0 on SYSCALL and streams
// ASCII bytes (decimal integers, memory strings, single chars) on a valid/ready port.
module syscall_unit #(
  parameter int MAX_STR = 256,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              syscall,
  input  logic [31:0]       sys_call_reg,
  input  logic [31:0]       std_out_address,
  output logic              stall,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic              out_valid,
  output logic [7:0]        out_data,
  input  logic              out_ready,
  output logic              halted,
  output logic              bad_service
);

  localparam int CNT_W = $clog2(MAX_STR + 1);

  typedef enum logic [2:0] {
    IDLE, INT_SIGN, INT_DIG, STR_REQ, STR_WAIT, EMIT, DONE, HALT
  } state_t;

  state_t            state_reg, state_next;
  state_t            ret_reg, ret_next;
  logic [31:0]       arg_reg, arg_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic [31:0]       mag_reg, mag_next;
  logic [3:0]        pow_idx_reg, pow_idx_next;
  logic [3:0]        digit_reg, digit_next;
  logic              started_reg, started_next;
  logic [7:0]        out_data_reg, out_data_next;
  logic              bad_service_reg, bad_service_next;

  function automatic logic [31:0] pow10(input logic [3:0] p);
    case (p)
      4'd0:    pow10 = 32'd1;
      4'd1:    pow10 = 32'd10;
      4'd2:    pow10 = 32'd100;
      4'd3:    pow10 = 32'd1000;
      4'd4:    pow10 = 32'd10000;
      4'd5:    pow10 = 32'd100000;
      4'd6:    pow10 = 32'd1000000;
      4'd7:    pow10 = 32'd10000000;
      4'd8:    pow10 = 32'd100000000;
      default: pow10 = 32'd1000000000;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg       <= IDLE;
      ret_reg         <= IDLE;
      arg_reg         <= '0;
      count_reg       <= '0;
      mag_reg         <= '0;
      pow_idx_reg     <= '0;
      digit_reg       <= '0;
      started_reg     <= 1'b0;
      out_data_reg    <= '0;
      bad_service_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      ret_reg         <= ret_next;
      arg_reg         <= arg_next;
      count_reg       <= count_next;
      mag_reg         <= mag_next;
      pow_idx_reg     <= pow_idx_next;
      digit_reg       <= digit_next;
      started_reg     <= started_next;
      out_data_reg    <= out_data_next;
      bad_service_reg <= bad_service_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    ret_next         = ret_reg;
    arg_next         = arg_reg;
    count_next       = count_reg;
    mag_next         = mag_reg;
    pow_idx_next     = pow_idx_reg;
    digit_next       = digit_reg;
    started_next     = started_reg;
    out_data_next    = out_data_reg;
    bad_service_next = 1'b0;
    case (state_reg)
      IDLE: begin
        if (syscall) begin
          arg_next   = std_out_address;
          count_next = '0;
          case (sys_call_reg)
            32'd1:  state_next = INT_SIGN;
            32'd4:  state_next = STR_REQ;
            32'd10: state_next = HALT;
            32'd11: begin
              out_data_next = std_out_address[7:0];
              ret_next      = DONE;
              state_next    = EMIT;
            end
            default: begin
              bad_service_next = 1'b1;
              state_next       = DONE;
            end
          endcase
        end
      end
      INT_SIGN: begin
        pow_idx_next = 4'd9;
        digit_next   = 4'd0;
        started_next = 1'b0;
        if (arg_reg[31]) begin
          mag_next      = ~arg_reg + 32'd1;
          out_data_next = 8'h2D;
          ret_next      = INT_DIG;
          state_next    = EMIT;
        end else if (arg_reg == 32'd0) begin
          out_data_next = 8'h30;
          ret_next      = DONE;
          state_next    = EMIT;
        end else begin
          mag_next   = arg_reg;
          state_next = INT_DIG;
        end
      end
      INT_DIG: begin
        if (mag_reg >= pow10(pow_idx_reg)) begin
          mag_next   = mag_reg - pow10(pow_idx_reg);
          digit_next = digit_reg + 4'd1;
        end else begin
          // Digit for this power is final; leading zeros are skipped until the first non-zero.
          digit_next = 4'd0;
          if (pow_idx_reg != 4'd0)
            pow_idx_next = pow_idx_reg - 4'd1;
          if (digit_reg != 4'd0 || started_reg) begin
            out_data_next = 8'h30 + {4'h0, digit_reg};
            started_next  = 1'b1;
            ret_next      = (pow_idx_reg == 4'd0) ? DONE : INT_DIG;
            state_next    = EMIT;
          end else begin
            state_next = (pow_idx_reg == 4'd0) ? DONE : INT_DIG;
          end
        end
      end
      STR_REQ:  state_next = STR_WAIT;
      STR_WAIT: begin
        if (mem_rdata == 8'h00 || count_reg == CNT_W'(MAX_STR)) begin
          state_next = DONE;
        end else begin
          out_data_next = mem_rdata;
          count_next    = count_reg + 1'b1;
          ret_next      = STR_REQ;
          state_next    = EMIT;
        end
      end
      EMIT:    if (out_ready) state_next = ret_reg;
      DONE:    state_next = IDLE;
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  assign stall       = (state_reg != IDLE) | (syscall & (state_reg == IDLE));
  assign mem_rd      = (state_reg == STR_REQ);
  assign mem_addr    = mem_rd ? (ADDR_W'(arg_reg) + ADDR_W'(count_reg)) : '0;
  assign out_valid   = (state_reg == EMIT);
  assign out_data    = out_data_reg;
  assign halted      = (state_reg == HALT);
  assign bad_service = bad_service_reg;

endmodule

// File: tb/tb_syscall_unit.sv
// Directed bench for syscall_unit: table of services with expected console text,
// plus sequences for back-pressure, string truncation, reset abort and exit.
module tb_syscall_unit;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        syscall = 1'b0;
  logic [31:0] sys_call_reg = '0;
  logic [31:0] std_out_address = '0;
  logic        stall, mem_rd, out_valid, halted, bad_service;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata, out_data;
  logic        out_ready = 1'b1;

  always #5 clk = ~clk;

  syscall_unit #(.MAX_STR(256), .ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .syscall(syscall), .sys_call_reg(sys_call_reg),
    .std_out_address(std_out_address), .stall(stall), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_rdata(mem_rdata), .out_valid(out_valid),
    .out_data(out_data), .out_ready(out_ready), .halted(halted),
    .bad_service(bad_service)
  );

  logic [7:0] mem [0:4095];
  always @(posedge clk) if (mem_rd) mem_rdata <= mem[mem_addr[11:0]];

  int n_cmp = 0;
  int n_fail = 0;
  int ready_mode = 0;   // 0: always ready, 1: toggle, 2: never ready
  logic [7:0]  got[$];
  logic [31:0] rd_addrs[$];
  int bad_pulses = 0;
  bit hold_pending = 1'b0;
  logic [7:0] held = '0;

  // Sink and monitor: drive out_ready, then sample outputs mid-cycle.
  always @(negedge clk) begin
    case (ready_mode)
      1:       out_ready = ~out_ready;
      2:       out_ready = 1'b0;
      default: out_ready = 1'b1;
    endcase
    #1;
    if (hold_pending && !reset) begin
      n_cmp++;
      if (!out_valid || out_data !== held) begin
        n_fail++;
        $display("FAIL hold_stable: valid=%0b data=%02h required valid=1 data=%02h",
                 out_valid, out_data, held);
      end
    end
    hold_pending = out_valid && !out_ready && !reset;
    held = out_data;
    if (out_valid && out_ready && !reset) got.push_back(out_data);
    if (mem_rd) rd_addrs.push_back(mem_addr);
    if (bad_service) bad_pulses++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic issue(input logic [31:0] code, input logic [31:0] arg);
    got.delete();
    rd_addrs.delete();
    bad_pulses = 0;
    @(negedge clk);
    syscall = 1'b1;
    sys_call_reg = code;
    std_out_address = arg;
    #2;
    check("stall_same_cycle", {31'd0, stall}, 32'd1);
    @(posedge clk);
    #1 syscall = 1'b0;
  endtask

  task automatic run_service(input logic [31:0] code, input logic [31:0] arg);
    bit done;
    issue(code, arg);
    done = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      @(negedge clk);
      #2;
      if (!stall) begin
        done = 1'b1;
        break;
      end
    end
    check("service_completes", {31'd0, done}, 32'd1);
    @(negedge clk);
    #2;
    check("idle_after_done", {31'd0, stall}, 32'd0);
  endtask

  task automatic check_text(input string name, input logic [95:0] text, input int len);
    check({name, "_len"}, got.size(), len);
    for (int i = 0; i < len && i < got.size(); i++)
      check({name, "_byte"}, {24'd0, got[i]}, {24'd0, text[8*(len-1-i) +: 8]});
  endtask

  typedef struct packed {
    logic [31:0] code;
    logic [31:0] arg;
    logic [95:0] text;
    logic [7:0]  len;
  } vec_t;

  vec_t vecs [9];

  initial begin
    vecs[0] = '{32'd11, 32'h41,        96'("A"),           8'd1};
    vecs[1] = '{32'd1,  32'd0,         96'("0"),           8'd1};
    vecs[2] = '{32'd1,  32'd305,       96'("305"),         8'd3};
    vecs[3] = '{32'd1,  32'hFFFF_FFF9, 96'("-7"),          8'd2};
    vecs[4] = '{32'd1,  32'h8000_0000, 96'("-2147483648"), 8'd11};
    vecs[5] = '{32'd1,  32'd1000000000,96'("1000000000"),  8'd10};
    vecs[6] = '{32'd1,  32'h7FFF_FFFF, 96'("2147483647"),  8'd10};
    vecs[7] = '{32'd11, 32'h17A,       96'("z"),           8'd1};
    vecs[8] = '{32'd4,  32'h100,       96'("Hi"),          8'd2};

    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    mem[12'h100] = 8'h48;
    mem[12'h101] = 8'h69;
    for (int i = 0; i < 300; i++) mem[12'h400 + i] = 8'h21 + 8'(i % 90);

    // Reset state
    repeat (2) @(negedge clk);
    #2;
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    check("rst_bad_service", {31'd0, bad_service}, 32'd0);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      run_service(vecs[v].code, vecs[v].arg);
      check_text("vec_text", vecs[v].text, int'(vecs[v].len));
      check("vec_no_bad", bad_pulses, 0);
      $display("vector %0d: code=%0d arg=%08h bytes=%0d", v, vecs[v].code, vecs[v].arg, got.size());
    end

    // String under back-pressure; NUL read but not emitted
    ready_mode = 1;
    run_service(32'd4, 32'h100);
    ready_mode = 0;
    check_text("hi_toggle", 96'("Hi"), 2);
    check("hi_rd_count", rd_addrs.size(), 3);
    for (int i = 0; i < 3 && i < rd_addrs.size(); i++)
      check("hi_rd_addr", rd_addrs[i], 32'h100 + i);
    $display("string toggle: bytes=%0d reads=%0d", got.size(), rd_addrs.size());

    // 300-byte string truncated at MAX_STR
    run_service(32'd4, 32'h400);
    check("long_len", got.size(), 256);
    for (int i = 0; i < 256 && i < got.size(); i++)
      check("long_byte", {24'd0, got[i]}, {24'd0, 8'h21 + 8'(i % 90)});
    $display("long string: bytes=%0d", got.size());

    // Unsupported service
    run_service(32'd99, 32'h0);
    check("bad_pulse_count", bad_pulses, 1);
    check("bad_no_output", got.size(), 0);
    $display("bad service: pulses=%0d bytes=%0d", bad_pulses, got.size());

    // Reset while a byte is pending
    ready_mode = 2;
    issue(32'd4, 32'h400);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 50; i++) begin
        @(negedge clk);
        #2;
        if (out_valid) begin
          seen = 1'b1;
          break;
        end
      end
      check("mid_reset_valid_seen", {31'd0, seen}, 32'd1);
    end
    reset = 1'b1;
    #1;
    check("mid_reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("mid_reset_stall", {31'd0, stall}, 32'd0);
    check("mid_reset_mem_rd", {31'd0, mem_rd}, 32'd0);
    ready_mode = 0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_service(32'd11, 32'h51);
    check_text("after_reset", 96'("Q"), 1);
    $display("reset abort then print_char: bytes=%0d", got.size());

    // Exit is sticky and ignores further syscalls
    issue(32'd10, 32'h0);
    repeat (5) @(negedge clk);
    #2;
    check("halt_halted", {31'd0, halted}, 32'd1);
    check("halt_stall", {31'd0, stall}, 32'd1);
    issue(32'd11, 32'h58);
    repeat (10) @(negedge clk);
    #2;
    check("halt_ignores_syscall", got.size(), 0);
    check("halt_still_halted", {31'd0, halted}, 32'd1);
    check("halt_still_stall", {31'd0, stall}, 32'd1);
    $display("exit: halted=%0b stall=%0b bytes=%0d", halted, stall, got.size());

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
